pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 120 ++++++++++++
 tb/tb_pwm_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input
// in clk cycles. Reports each completed period with a one-cycle meas_valid
// pulse and flags a missing/static input once the counter saturates.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             no_signal,
  output logic             stuck_level
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_lvl;
  logic                   rise;
  logic                   fall;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hi_tmp;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~prev_q;
  assign fall     = ~sync_lvl & prev_q;

  // Synchronizer chain plus one delay flop for edge detection; both edges
  // share the same path so rise and fall latencies match exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= sync_lvl;
    end
  end

  // Measurement FSM: cnt counts cycles since the last rise; the fall
  // snapshots the high time, the next rise publishes the full period.
  // Saturation is checked before edges so cnt can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_tmp      <= '0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      meas_valid  <= 1'b0;
      no_signal   <= 1'b0;
      stuck_level <= 1'b0;
    end else if (!en) begin
      state      <= IDLE;
      cnt        <= '0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= CNT_ONE;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (cnt == CNT_MAX) begin
            state       <= IDLE;
            cnt         <= '0;
            no_signal   <= 1'b1;
            stuck_level <= sync_lvl;
          end else if (rise) begin
            cnt <= CNT_ONE;
          end else if (fall) begin
            hi_tmp <= cnt;
            cnt    <= cnt + CNT_ONE;
            state  <= LOW;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        LOW: begin
          if (cnt == CNT_MAX) begin
            state       <= IDLE;
            cnt         <= '0;
            no_signal   <= 1'b1;
            stuck_level <= sync_lvl;
          end else if (rise) begin
            period_cnt <= cnt;
            high_cnt   <= hi_tmp;
            meas_valid <= 1'b1;
            no_signal  <= 1'b0;
            cnt        <= CNT_ONE;
            state      <= HIGH;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=4 so saturation is reachable).
module tb_pwm_capture;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period_cnt;
  logic [W-1:0] high_cnt;
  logic         meas_valid;
  logic         no_signal;
  logic         stuck_level;

  pwm_capture #(.CNT_W(W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_valid (meas_valid),
    .no_signal  (no_signal),
    .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
  } meas_t;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_period;
    int exp_high;
    int exp_count;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  meas_t q[$];
  logic  prev_v = 1'b0;
  int    dis_valids = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Record every measurement; a pulse must never last two cycles.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      check("valid_one_cycle", int'(prev_v), 0);
      q.push_back('{p: int'(period_cnt), h: int'(high_cnt)});
      if (!en) dis_valids++;
    end
    prev_v = meas_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    pwm_in = 1'b1;
    tick(hi);
    pwm_in = 1'b0;
    tick(lo);
  endtask

  // Final rise that publishes the preceding period.
  task automatic trail();
    pwm_in = 1'b1;
    tick(6);
    pwm_in = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    en     = 1'b1;
    rst    = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    q.delete();
  endtask

  task automatic check_q(input string nm, input int cnt, input int p, input int h);
    check({nm, "_count"}, q.size(), cnt);
    foreach (q[i]) begin
      check({nm, "_period"}, q[i].p, p);
      check({nm, "_high"}, q[i].h, h);
    end
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{hi: 3, lo: 7,  reps: 3, exp_period: 10, exp_high: 3, exp_count: 3};
    vecs[1] = '{hi: 1, lo: 1,  reps: 4, exp_period: 2,  exp_high: 1, exp_count: 4};
    vecs[2] = '{hi: 8, lo: 2,  reps: 2, exp_period: 10, exp_high: 8, exp_count: 2};
    vecs[3] = '{hi: 1, lo: 13, reps: 2, exp_period: 14, exp_high: 1, exp_count: 2};
    vecs[4] = '{hi: 5, lo: 1,  reps: 2, exp_period: 6,  exp_high: 5, exp_count: 2};
    vecs[5] = '{hi: 2, lo: 2,  reps: 3, exp_period: 4,  exp_high: 2, exp_count: 3};

    // Reset state
    rst = 1'b1;
    #3;
    check("rst_period", int'(period_cnt), 0);
    check("rst_high", int'(high_cnt), 0);
    check("rst_valid", int'(meas_valid), 0);
    check("rst_nosig", int'(no_signal), 0);
    check("rst_stuck", int'(stuck_level), 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Steady-state waveforms
    foreach (vecs[k]) begin
      do_reset();
      for (int r = 0; r < vecs[k].reps; r++) pulse(vecs[k].hi, vecs[k].lo);
      trail();
      check_q($sformatf("vec%0d", k), vecs[k].exp_count, vecs[k].exp_period, vecs[k].exp_high);
      check($sformatf("vec%0d_nosig", k), int'(no_signal), 0);
    end

    // Duty change 3/10 -> 8/10 mid-stream
    do_reset();
    repeat (3) pulse(3, 7);
    repeat (2) pulse(8, 2);
    trail();
    check("duty_count", q.size(), 5);
    if (q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("duty_period", q[i].p, 10);
        check("duty_high", q[i].h, (i < 3) ? 3 : 8);
      end
    end

    // Timeout with input stuck low, then stuck high
    do_reset();
    pulse(3, 7);
    pwm_in = 1'b1;
    tick(3);
    pwm_in = 1'b0;
    for (int i = 0; i < 40 && no_signal !== 1'b1; i++) tick(1);
    check("to_low_nosig", int'(no_signal), 1);
    check("to_low_stuck", int'(stuck_level), 0);
    check("to_low_period", int'(period_cnt), 10);
    check("to_low_high", int'(high_cnt), 3);
    check("to_low_count", q.size(), 1);
    pwm_in = 1'b1;
    for (int i = 0; i < 40 && stuck_level !== 1'b1; i++) tick(1);
    check("to_high_stuck", int'(stuck_level), 1);
    check("to_high_nosig", int'(no_signal), 1);
    check("to_high_period", int'(period_cnt), 10);
    pwm_in = 1'b0;
    tick(7);
    q.delete();
    pulse(3, 7);
    trail();
    check_q("recover", 1, 10, 3);
    check("recover_nosig", int'(no_signal), 0);

    // Asynchronous reset during the LOW phase
    do_reset();
    pulse(3, 7);
    pwm_in = 1'b1;
    tick(3);
    pwm_in = 1'b0;
    tick(3);
    check("pre_rst_period", int'(period_cnt), 10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_period", int'(period_cnt), 0);
    check("arst_high", int'(high_cnt), 0);
    check("arst_valid", int'(meas_valid), 0);
    check("arst_nosig", int'(no_signal), 0);
    check("arst_stuck", int'(stuck_level), 0);
    tick(1);
    rst = 1'b0;
    q.delete();
    tick(4);
    pulse(3, 7);
    trail();
    check_q("post_rst", 1, 10, 3);

    // Enable dropped mid-period for 5 cycles
    do_reset();
    pulse(3, 7);
    pwm_in = 1'b1;
    tick(3);
    pwm_in = 1'b0;
    tick(2);
    en = 1'b0;
    tick(5);
    check("dis_hold_period", int'(period_cnt), 10);
    check("dis_hold_high", int'(high_cnt), 3);
    en = 1'b1;
    tick(5);
    check("dis_valids", dis_valids, 0);
    check("en_pre_count", q.size(), 1);
    q.delete();
    pwm_in = 1'b1;
    tick(3);
    pwm_in = 1'b0;
    tick(7);
    check("en_first_rise_count", q.size(), 0);
    trail();
    check_q("en_restore", 1, 10, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
